// File: rtl/mcu_bus_pkg.sv
// Shared constants for the external MCU bus responder: register addresses,
// status flag positions and the access-sequencer state encoding.
package mcu_bus_pkg;

    localparam logic [7:0] B0_ADDR      = 8'd0;
    localparam logic [7:0] B1_ADDR      = 8'd1;
    localparam logic [7:0] B2_ADDR      = 8'd2;
    localparam logic [7:0] B3_ADDR      = 8'd3;
    localparam logic [7:0] B4_ADDR      = 8'd4;
    localparam logic [7:0] B5_ADDR      = 8'd5;
    localparam logic [7:0] B6_ADDR      = 8'd6;
    localparam logic [7:0] OPERAND_ADDR = 8'd7;
    localparam logic [7:0] HOUR_ADDR    = 8'd8;
    localparam logic [7:0] MINUTE_ADDR  = 8'd9;
    localparam logic [7:0] STATUS_ADDR  = 8'd10;

    localparam int ST_HOUR   = 0;
    localparam int ST_MINUTE = 1;
    localparam int ST_ADDR   = 2;
    localparam int ST_RW     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/mcu_bus_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous strobe, with a history flop
// that yields single-cycle rise/fall pulses in the clock domain.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/mcu_bus_slave.sv
// Chip-side responder for the external MCU bus: latches the address on ALE,
// commits validated writes into the configuration registers and serves reads.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no access in flight; watching for a Wbar or Rbar strobe
//   S_WRITE | write strobe active; commit on the synced Wbar rise
//   S_READ  | read strobe active; drive DBUS until Rbar or CSbar rises
module mcu_bus_slave
    import mcu_bus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] HOUR_MAX    = 8'd23,
    parameter logic [7:0] MINUTE_MAX  = 8'd59
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ABUS,
    input  logic [7:0]  dbus_in,
    output logic [7:0]  dbus_out,
    output logic        dbus_oe,
    input  logic        CSbar,
    input  logic        ALE,
    input  logic        Rbar,
    input  logic        Wbar,
    output logic [55:0] b_regs,
    output logic [7:0]  operand,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [9:0]  wr_pulse,
    output logic [3:0]  status
);

    logic ale_sync, ale_rise, ale_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic r_sync, r_rise, r_fall;
    logic w_sync, w_rise, w_fall;
    logic unused_sync;

    logic [7:0] abus_q, dbus_q, addr_q, addr_pend;
    logic       pend_q;

    bus_state_t state, state_next;
    logic       do_write, do_drive, read_done, rw_err;
    logic [9:0] wr_hit;
    logic [3:0] err_new;
    logic [7:0] rd_data;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ale (
        .clock(clock), .reset(reset), .din(ALE),
        .dout(ale_sync), .rise(ale_rise), .fall(ale_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .din(CSbar),
        .dout(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_r (
        .clock(clock), .reset(reset), .din(Rbar),
        .dout(r_sync), .rise(r_rise), .fall(r_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_w (
        .clock(clock), .reset(reset), .din(Wbar),
        .dout(w_sync), .rise(w_rise), .fall(w_fall)
    );

    assign unused_sync = ^{ale_sync, ale_rise, cs_rise, cs_fall, r_rise, r_fall, w_fall};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_drive   = 1'b0;
        read_done  = 1'b0;
        rw_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cs_sync && !w_sync && r_sync) begin
                    state_next = S_WRITE;
                end else if (!cs_sync && !r_sync && w_sync) begin
                    state_next = S_READ;
                end else if (!r_sync && !w_sync) begin
                    rw_err = 1'b1;
                end
            end
            S_WRITE: begin
                if (w_rise) begin
                    do_write   = 1'b1;
                    state_next = S_IDLE;
                end else if (cs_sync) begin
                    state_next = S_IDLE;
                end
            end
            S_READ: begin
                if (r_sync || cs_sync) begin
                    read_done  = r_sync;
                    state_next = S_IDLE;
                end else begin
                    do_drive = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Write validation: out-of-range time values and unmapped addresses raise flags instead.
    always_comb begin
        wr_hit          = '0;
        err_new         = '0;
        err_new[ST_RW]  = rw_err;
        if (do_write) begin
            if (addr_q <= OPERAND_ADDR) begin
                wr_hit[addr_q[2:0]] = 1'b1;
            end else if (addr_q == HOUR_ADDR) begin
                if (dbus_q <= HOUR_MAX) wr_hit[8] = 1'b1;
                else                    err_new[ST_HOUR] = 1'b1;
            end else if (addr_q == MINUTE_ADDR) begin
                if (dbus_q <= MINUTE_MAX) wr_hit[9] = 1'b1;
                else                      err_new[ST_MINUTE] = 1'b1;
            end else begin
                err_new[ST_ADDR] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_q <= B6_ADDR) begin
            rd_data = b_regs[{addr_q[2:0], 3'b000} +: 8];
        end else begin
            case (addr_q)
                OPERAND_ADDR: rd_data = operand;
                HOUR_ADDR:    rd_data = hour;
                MINUTE_ADDR:  rd_data = minute;
                STATUS_ADDR:  rd_data = {4'b0000, status};
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            abus_q    <= '0;
            dbus_q    <= '0;
            addr_q    <= '0;
            addr_pend <= '0;
            pend_q    <= 1'b0;
            b_regs    <= '0;
            operand   <= '0;
            hour      <= '0;
            minute    <= '0;
            wr_pulse  <= '0;
            status    <= '0;
            dbus_out  <= '0;
            dbus_oe   <= 1'b0;
        end else begin
            abus_q   <= ABUS;
            dbus_q   <= dbus_in;
            wr_pulse <= wr_hit;
            dbus_oe  <= do_drive;
            if (do_drive) dbus_out <= rd_data;

            // An address arriving mid-access is parked until the access finishes.
            if (ale_fall) begin
                if (state == S_IDLE) begin
                    addr_q <= abus_q;
                    pend_q <= 1'b0;
                end else begin
                    addr_pend <= abus_q;
                    pend_q    <= 1'b1;
                end
            end else if (pend_q && state == S_IDLE) begin
                addr_q <= addr_pend;
                pend_q <= 1'b0;
            end

            for (int k = 0; k < 7; k++) begin
                if (wr_hit[k]) b_regs[k*8 +: 8] <= dbus_q;
            end
            if (wr_hit[7]) operand <= dbus_q;
            if (wr_hit[8]) hour    <= dbus_q;
            if (wr_hit[9]) minute  <= dbus_q;

            status <= ((read_done && addr_q == STATUS_ADDR) ? 4'h0 : status) | err_new;
        end
    end

endmodule

// File: tb/tb_mcu_bus_slave.sv
// Scoreboard bench for mcu_bus_slave: bus tasks push expected responses from a
// register-map model, a negedge monitor pops and compares as the DUT responds.
module tb_mcu_bus_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ABUS = '0;
    logic [7:0]  dbus_in = '0;
    logic        CSbar = 1'b1;
    logic        ALE = 1'b0;
    logic        Rbar = 1'b1;
    logic        Wbar = 1'b1;
    logic [7:0]  dbus_out;
    logic        dbus_oe;
    logic [55:0] b_regs;
    logic [7:0]  operand, hour, minute;
    logic [9:0]  wr_pulse;
    logic [3:0]  status;

    mcu_bus_slave dut (
        .clock(clock), .reset(reset), .ABUS(ABUS), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .dbus_oe(dbus_oe), .CSbar(CSbar), .ALE(ALE),
        .Rbar(Rbar), .Wbar(Wbar), .b_regs(b_regs), .operand(operand),
        .hour(hour), .minute(minute), .wr_pulse(wr_pulse), .status(status)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         due;
    } wr_exp_t;

    wr_exp_t    wq[$];
    logic [7:0] rq[$];
    wr_exp_t    mon_e;
    logic [7:0] m_reg[10];
    logic [3:0] m_status;
    bit         rd_window = 1'b0;
    logic       oe_prev = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dut_reg(int a);
        if (a < 7)       return b_regs[a*8 +: 8];
        else if (a == 7) return operand;
        else if (a == 8) return hour;
        else if (a == 9) return minute;
        return 8'h00;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (wr_pulse != '0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr_pulse", 64'(wr_pulse), 64'd0);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_pulse_vec", 64'(wr_pulse), 64'(10'b1 << mon_e.addr));
                    chk("wr_pulse_time", 64'(cyc), 64'(mon_e.due));
                    chk("wr_reg_value", 64'(dut_reg(mon_e.addr)), 64'(mon_e.data));
                end
            end
            if (dbus_oe && !rd_window) chk("oe_outside_read", 64'(dbus_oe), 64'd0);
            if (dbus_oe && !oe_prev) begin
                if (rq.size() == 0) chk("unexpected_read", 64'(dbus_oe), 64'd0);
                else                chk("read_data", 64'(dbus_out), 64'(rq.pop_front()));
            end
        end
        oe_prev = dbus_oe;
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) m_reg[i] = 8'h00;
        m_status = 4'h0;
    endtask

    task automatic set_addr(int a);
        ABUS = 8'(a);
        ALE  = 1'b1;
        tick(3);
        ALE = 1'b0;
        tick(4);
    endtask

    task automatic do_write(int a, logic [7:0] d);
        bit ok;
        set_addr(a);
        dbus_in = d;
        CSbar   = 1'b0;
        Wbar    = 1'b0;
        tick(5);
        Wbar = 1'b1;
        ok = 1'b0;
        if (a <= 7)      ok = 1'b1;
        else if (a == 8) begin if (d <= 8'd23) ok = 1'b1; else m_status[0] = 1'b1; end
        else if (a == 9) begin if (d <= 8'd59) ok = 1'b1; else m_status[1] = 1'b1; end
        else             m_status[2] = 1'b1;
        if (ok) begin
            m_reg[a] = d;
            wq.push_back('{a, d, cyc + 3});
        end
        tick(4);
        CSbar = 1'b1;
        tick(3);
    endtask

    task automatic do_read(int a);
        logic [7:0] exp;
        set_addr(a);
        if (a < 10)       exp = m_reg[a];
        else if (a == 10) exp = {4'b0000, m_status};
        else              exp = 8'h00;
        rq.push_back(exp);
        rd_window = 1'b1;
        CSbar = 1'b0;
        Rbar  = 1'b0;
        tick(6);
        Rbar = 1'b1;
        tick(1);
        CSbar = 1'b1;
        tick(5);
        rd_window = 1'b0;
        if (a == 10) m_status = 4'h0;
    endtask

    task automatic check_all(string tag);
        for (int a = 0; a < 10; a++) chk({tag, "_reg"}, 64'(dut_reg(a)), 64'(m_reg[a]));
        chk({tag, "_status"}, 64'(status), 64'(m_status));
    endtask

    initial begin
        int a, op, r;
        logic [7:0] d;
        model_clear();
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("rst_b_regs", b_regs, 64'd0);
        chk("rst_oe", 64'(dbus_oe), 64'd0);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_time", {hour, minute, operand}, 64'd0);

        for (int i = 0; i <= 10; i++) do_read(i);

        do_write(8, 8'd23);
        do_write(9, 8'd33);
        chk("hour_23", 64'(hour), 64'd23);
        chk("minute_33", 64'(minute), 64'd33);
        do_read(8);
        do_read(9);

        do_write(8, 8'd24);
        do_write(9, 8'd60);
        chk("time_unchanged", {hour, minute}, {48'd0, 8'd23, 8'd33});
        chk("status_0011", 64'(status), 64'h3);
        do_read(10);
        do_read(10);
        chk("status_cleared", 64'(status), 64'h0);

        for (int i = 0; i < 7; i++) do_write(i, 8'h0A);
        do_write(7, 8'hFF);
        chk("b_regs_0a", b_regs, 64'h0A0A0A0A0A0A0A);
        chk("operand_ff", 64'(operand), 64'hFF);
        do_write(200, 8'h77);
        chk("status_addr_err", 64'(status[2]), 64'd1);
        do_read(200);

        set_addr(3);
        CSbar = 1'b0;
        Rbar  = 1'b0;
        Wbar  = 1'b0;
        tick(5);
        Rbar  = 1'b1;
        Wbar  = 1'b1;
        CSbar = 1'b1;
        tick(4);
        m_status[3] = 1'b1;
        check_all("rw_clash");

        set_addr(7);
        dbus_in = 8'h55;
        CSbar   = 1'b0;
        Wbar    = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(2);
        Wbar  = 1'b1;
        CSbar = 1'b1;
        tick(2);
        reset = 1'b0;
        model_clear();
        tick(6);
        chk("abort_operand", 64'(operand), 64'd0);
        chk("abort_oe", 64'(dbus_oe), 64'd0);
        do_write(7, 8'h5A);
        chk("post_reset_write", 64'(operand), 64'h5A);

        repeat (40) begin
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            a  = (r < 8) ? $urandom_range(0, 10) : $urandom_range(11, 255);
            if (a == 8)      d = 8'($urandom_range(0, 30));
            else if (a == 9) d = 8'($urandom_range(0, 70));
            else             d = 8'($urandom);
            if (op < 2) do_write(a, d);
            else        do_read(a);
        end
        check_all("random");

        tick(4);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
